// File: rtl/sbrk_input_pkg.sv
// sbrk_input_pkg: shared types, PS/2 mouse packet bit positions and helper
// functions for the super_breakout mouse steering path.
package sbrk_input_pkg;

    // Two-bit quadrature phase; sequence 00->01->11->10 is "forward".
    typedef logic [1:0] quad_phase_t;

    // Bit positions inside the 25-bit ps2_mouse bus.
    localparam int PS2M_TOGGLE = 24;
    localparam int PS2M_XSIGN  = 4;
    localparam int PS2M_LBTN   = 0;

    // Next phase when stepping forward (gray sequence, one bit changes).
    function automatic quad_phase_t QUAD_FWD(input quad_phase_t p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Next phase when stepping in reverse (inverse of QUAD_FWD).
    function automatic quad_phase_t QUAD_REV(input quad_phase_t p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Signed add clamped to [-lim, +lim]; the sum is formed one bit wider
    // so it cannot wrap before the clamp is applied.
    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b,
                                                   input logic signed [15:0] lim);
        logic signed [16:0] s;
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        s  = {a[15], a} + {b[15], b};
        hi = {lim[15], lim};
        lo = -hi;
        if (s > hi)
            return lim;
        else if (s < lo)
            return -lim;
        else
            return s[15:0];
    endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// quad_phase_gen: registered 2-bit gray-code phase FSM. One step forward or
// reverse per asserted request; the phase register is exported as o_phase.
module quad_phase_gen
    import sbrk_input_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fwd,
    input  logic        i_rev,
    output quad_phase_t o_phase
);

    quad_phase_t r_phase;
    quad_phase_t w_phase_next;

    // Next-phase selection; forward wins if both are requested (never happens).
    always_comb begin
        w_phase_next = r_phase;
        if (i_fwd)
            w_phase_next = QUAD_FWD(r_phase);
        else if (i_rev)
            w_phase_next = QUAD_REV(r_phase);
    end

    // Phase state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_phase <= 2'b00;
        else
            r_phase <= w_phase_next;
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/mouse_to_quad.sv
// mouse_to_quad: accumulates PS/2 mouse X motion and releases it as paced
// quadrature steps on enc_a/enc_b; forwards the left button as serve.
// Optional feature macro: MOUSE_QUAD_JOY_EN adds joy_left/joy_right inputs
// that inject +/-1 per pacer tick into the accumulator.
//
// Packet protocol: the mouse side flips ps2_mouse[24] once per new packet and
// holds the payload stable; a packet is taken in the single cycle in which the
// toggle bit differs from its registered copy. There is no back-pressure.
module mouse_to_quad
    import sbrk_input_pkg::*;
#(
    parameter int ACC_W       = 10,
    parameter int SCALE_SHIFT = 0
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] clkdiv,
`ifdef MOUSE_QUAD_JOY_EN
    input  logic        joy_left,
    input  logic        joy_right,
`endif
    output logic        enc_a,
    output logic        enc_b,
    output logic        serve,
    output logic        busy
);

    localparam logic signed [15:0] ACC_LIM = 16'((1 << (ACC_W - 1)) - 1);

    logic                    r_toggle_q;
    logic                    r_armed;
    logic                    r_serve;
    logic                    r_busy;
    logic [15:0]             r_pacer;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_pkt;
    logic signed [8:0]       w_dx;
    logic                    w_tick;
    logic                    w_acc_pos;
    logic                    w_acc_neg;
    logic                    w_step_fwd;
    logic                    w_step_rev;
    logic signed [15:0]      w_delta;
    logic signed [15:0]      w_acc_wide;
    logic signed [15:0]      w_sum;
    logic [ACC_W-1:0]        w_acc_next;
    quad_phase_t             w_phase;
    logic                    w_unused_bits;

    // Packet strobe and scaled 9-bit signed X delta.
    assign w_pkt = r_armed && (ps2_mouse[PS2M_TOGGLE] != r_toggle_q);
    assign w_dx  = $signed({ps2_mouse[PS2M_XSIGN], ps2_mouse[15:8]}) >>> SCALE_SHIFT;

    // Pacer fires when the down-counter reaches zero; reload 0 ticks every cycle.
    assign w_tick = (r_pacer == 16'd0);

    // Step direction is decided from the accumulator value before this cycle's update.
    assign w_acc_pos  = !r_acc[ACC_W-1] && (r_acc != '0);
    assign w_acc_neg  = r_acc[ACC_W-1];
    assign w_step_fwd = w_tick && w_acc_pos;
    assign w_step_rev = w_tick && w_acc_neg;

    // Combine packet delta, step consumption and optional joystick injection.
    always_comb begin
        w_delta = '0;
        if (w_pkt)
            w_delta = {{7{w_dx[8]}}, w_dx};
        if (w_step_fwd)
            w_delta = w_delta - 16'sd1;
        else if (w_step_rev)
            w_delta = w_delta + 16'sd1;
`ifdef MOUSE_QUAD_JOY_EN
        if (w_tick && joy_right && !joy_left)
            w_delta = w_delta + 16'sd1;
        else if (w_tick && joy_left && !joy_right)
            w_delta = w_delta - 16'sd1;
`endif
    end

    // Single saturating add keeps the accumulator inside +/-(2^(ACC_W-1)-1).
    assign w_acc_wide = {{(16 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_sum      = sat_add(w_acc_wide, w_delta, ACC_LIM);
    assign w_acc_next = w_sum[ACC_W-1:0];

    // Toggle capture; the first cycle out of reset only arms the detector.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_toggle_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_toggle_q <= ps2_mouse[PS2M_TOGGLE];
            r_armed    <= 1'b1;
        end
    end

    // Pacer down-counter, reloaded from clkdiv on reset and on every tick.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            r_pacer <= clkdiv;
        else if (w_tick)
            r_pacer <= clkdiv;
        else
            r_pacer <= r_pacer - 16'd1;
    end

    // Accumulator, busy flag (tracks acc != 0) and serve button latch.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_serve <= 1'b0;
        end else begin
            r_acc  <= w_acc_next;
            r_busy <= (w_acc_next != '0);
            if (w_pkt)
                r_serve <= ps2_mouse[PS2M_LBTN];
        end
    end

    quad_phase_gen u_phase (
        .i_clk   (CLK),
        .i_rst_n (Reset_n),
        .i_fwd   (w_step_fwd),
        .i_rev   (w_step_rev),
        .o_phase (w_phase)
    );

    assign enc_a = w_phase[1];
    assign enc_b = w_phase[0];
    assign serve = r_serve;
    assign busy  = r_busy;

    // Payload bits this block does not consume.
    assign w_unused_bits = ^{ps2_mouse[23:16], ps2_mouse[7:5], ps2_mouse[3:1],
                             w_sum[15:ACC_W]};

endmodule

// File: tb/tb_mouse_to_quad.sv
// tb_mouse_to_quad: directed bench for mouse_to_quad. Expected quadrature
// phases are queued when packets are issued; a monitor pops one per observed
// phase change.
module tb_mouse_to_quad;

    logic        CLK;
    logic        Reset_n;
    logic [24:0] ps2_mouse;
    logic [15:0] clkdiv;
    logic        enc_a;
    logic        enc_b;
    logic        serve;
    logic        busy;
`ifdef MOUSE_QUAD_JOY_EN
    logic        joy_left;
    logic        joy_right;
`endif

    logic [1:0] exp_q[$];
    int         chg_cyc[$];
    int         cyc;
    int         n_pass;
    int         n_total;
    logic [1:0] prev_phase;
    logic [1:0] model_phase;

    mouse_to_quad #(.ACC_W(10), .SCALE_SHIFT(0)) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .ps2_mouse (ps2_mouse),
        .clkdiv    (clkdiv),
`ifdef MOUSE_QUAD_JOY_EN
        .joy_left  (joy_left),
        .joy_right (joy_right),
`endif
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .serve     (serve),
        .busy      (busy)
    );

    // clock / cycle counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // reference gray sequences
    function automatic logic [1:0] ref_fwd(input logic [1:0] p);
        logic [1:0] t;
        case (p)
            2'b00: t = 2'b01;
            2'b01: t = 2'b11;
            2'b11: t = 2'b10;
            default: t = 2'b00;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] ref_rev(input logic [1:0] p);
        logic [1:0] t;
        case (p)
            2'b00: t = 2'b10;
            2'b10: t = 2'b11;
            2'b11: t = 2'b01;
            default: t = 2'b00;
        endcase
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // monitor: every phase change must match the head of the expected queue
    always @(negedge CLK) begin
        if (!Reset_n) begin
            prev_phase <= {enc_a, enc_b};
        end else if ({enc_a, enc_b} != prev_phase) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL step_unexpected: got phase %b at cycle %0d, expected no step",
                         {enc_a, enc_b}, cyc);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if ({enc_a, enc_b} == e)
                    n_pass++;
                else
                    $display("FAIL step_phase: got %b, expected %b (cycle %0d)",
                             {enc_a, enc_b}, e, cyc);
            end
            chg_cyc.push_back(cyc);
            prev_phase <= {enc_a, enc_b};
        end
    end

    // driver tasks
    task automatic expect_steps(input int n, input bit fwd);
        for (int i = 0; i < n; i++) begin
            model_phase = fwd ? ref_fwd(model_phase) : ref_rev(model_phase);
            exp_q.push_back(model_phase);
        end
    endtask

    task automatic do_reset(input logic [15:0] div, input bit chk);
        @(posedge CLK);
        #1;
        clkdiv  = div;
        Reset_n = 1'b0;
        #1;
        if (chk) begin
            check("reset_enc_a", int'(enc_a), 0);
            check("reset_enc_b", int'(enc_b), 0);
            check("reset_serve", int'(serve), 0);
            check("reset_busy", int'(busy), 0);
        end
        repeat (2) @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        model_phase = 2'b00;
        exp_q.delete();
        chg_cyc.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_pkt(input logic [8:0] dx, input logic btn);
        @(posedge CLK);
        #1;
        ps2_mouse[24]   = ~ps2_mouse[24];
        ps2_mouse[15:8] = dx[7:0];
        ps2_mouse[4]    = dx[8];
        ps2_mouse[0]    = btn;
    endtask

    task automatic sample_next;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        check(name, exp_q.size(), 0);
        repeat (12) @(negedge CLK);
    endtask

    task automatic check_spacing(input string name, input int gap);
        for (int i = 1; i < chg_cyc.size(); i++)
            check(name, chg_cyc[i] - chg_cyc[i-1], gap);
    endtask

    // stimulus
    initial begin
        cyc        = 0;
        n_pass     = 0;
        n_total    = 0;
        Reset_n    = 1'b0;
        ps2_mouse  = '0;
        clkdiv     = 16'd4;
        prev_phase = 2'b00;
        model_phase = 2'b00;
`ifdef MOUSE_QUAD_JOY_EN
        joy_left  = 1'b0;
        joy_right = 1'b0;
`endif
        repeat (2) @(posedge CLK);

        // 1: dX=+3, clkdiv=4 -> 3 forward steps 5 cycles apart
        do_reset(16'd4, 1'b1);
        expect_steps(3, 1'b1);
        send_pkt(9'sd3, 1'b0);
        sample_next();
        check("t1_busy_after_pkt", int'(busy), 1);
        wait_drain("t1_drain", 100);
        check("t1_nsteps", chg_cyc.size(), 3);
        check_spacing("t1_gap", 5);
        check("t1_busy_end", int'(busy), 0);
        check("t1_phase_end", int'({enc_a, enc_b}), 2);

        // 2: dX=-2 with left button -> 00->10->11, serve latched
        do_reset(16'd4, 1'b0);
        expect_steps(2, 1'b0);
        send_pkt(9'h1FE, 1'b1);
        sample_next();
        check("t2_serve_set", int'(serve), 1);
        check("t2_busy_after_pkt", int'(busy), 1);
        wait_drain("t2_drain", 100);
        check("t2_nsteps", chg_cyc.size(), 2);
        check("t2_phase_end", int'({enc_a, enc_b}), 3);
        check("t2_busy_end", int'(busy), 0);
        ps2_mouse[0] = 1'b0;
        repeat (3) @(negedge CLK);
        check("t2_serve_hold_no_pkt", int'(serve), 1);
        send_pkt(9'd0, 1'b0);
        sample_next();
        check("t2_serve_clear", int'(serve), 0);
        check("t2_zero_dx_busy", int'(busy), 0);

        // 3: toggle during reset is ignored, next toggle with dX=+1 -> 1 step
        @(posedge CLK);
        #1;
        Reset_n = 1'b0;
        ps2_mouse[24]   = ~ps2_mouse[24];
        ps2_mouse[15:8] = 8'd5;
        ps2_mouse[4]    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        model_phase = 2'b00;
        exp_q.delete();
        chg_cyc.delete();
        repeat (20) @(negedge CLK);
        check("t3_no_steps", chg_cyc.size(), 0);
        check("t3_busy_idle", int'(busy), 0);
        expect_steps(1, 1'b1);
        send_pkt(9'sd1, 1'b0);
        wait_drain("t3_drain", 100);
        check("t3_nsteps", chg_cyc.size(), 1);

        // 4: ten +127 packets back to back, clkdiv=0: acc saturates at 511.
        // 9 steps occur during the burst, then 511 drain steps.
        do_reset(16'd0, 1'b0);
        expect_steps(520, 1'b1);
        for (int i = 0; i < 10; i++)
            send_pkt(9'sd127, 1'b0);
        wait_drain("t4_drain", 700);
        check("t4_nsteps", chg_cyc.size(), 520);
        check("t4_busy_end", int'(busy), 0);

        // 5: clkdiv=0, dX=+4 then dX=+2 on the next cycle (coincides with a
        // step): acc = 4 + 2 - 1, so 6 steps on consecutive cycles
        do_reset(16'd0, 1'b0);
        expect_steps(6, 1'b1);
        send_pkt(9'sd4, 1'b0);
        send_pkt(9'sd2, 1'b0);
        wait_drain("t5_drain", 100);
        check("t5_nsteps", chg_cyc.size(), 6);
        check_spacing("t5_gap", 1);
        check("t5_phase_end", int'({enc_a, enc_b}), 3);

`ifdef MOUSE_QUAD_JOY_EN
        // 6: joy_right for 3 ticks -> 3 forward steps; both held -> none
        do_reset(16'd4, 1'b0);
        expect_steps(3, 1'b1);
        joy_right = 1'b1;
        repeat (15) @(posedge CLK);
        #1;
        joy_right = 1'b0;
        wait_drain("t6_drain", 100);
        check("t6_nsteps", chg_cyc.size(), 3);
        joy_right = 1'b1;
        joy_left  = 1'b1;
        repeat (30) @(negedge CLK);
        check("t6_both_no_steps", chg_cyc.size(), 3);
        check("t6_both_busy", int'(busy), 0);
        joy_right = 1'b0;
        joy_left  = 1'b0;
`endif

        check("leftover_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
